// File: rtl/sha_mem_arbiter.sv
// sha_mem_arbiter: shares one memory read port among N_CH sha256 cores.
// Each core's fire-and-forget read strobe is parked in a one-entry slot.
// Slots are round-robin arbitrated into a registered valid/ready request port.
// A tag FIFO of channel ids routes the in-order responses back to their requesters.
//
// Handshake (mem_req_*): a request transfers on a clock edge where
// mem_req_vld && mem_req_rdy. Once raised, mem_req_vld stays high and
// mem_req_addr stays stable until that edge. Responses (mem_rsp_vld) carry
// no ready, and they return in the same order the requests were issued.
module sha_mem_arbiter #(
    parameter int N_CH            = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_CH-1:0]                        ch_addr_vld,
    input  logic [N_CH*ADDR_W-1:0]                 ch_addr,
    output logic [N_CH-1:0]                        ch_data_vld,
    output logic [DATA_W-1:0]                      ch_data,
    output logic                                   mem_req_vld,
    input  logic                                   mem_req_rdy,
    output logic [ADDR_W-1:0]                      mem_req_addr,
    input  logic                                   mem_rsp_vld,
    input  logic [DATA_W-1:0]                      mem_rsp_data,
    output logic [N_CH-1:0]                        overflow,
    output logic                                   err_spurious,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   idle
);

    localparam int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_CH - 1);

    logic [N_CH-1:0]   slot_full;
    logic [ADDR_W-1:0] slot_addr [N_CH];
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_id;
    logic              win_found;
    int                idx;
    logic [N_CH-1:0]   grant;
    logic [N_CH-1:0]   rsp_onehot;
    logic              load;
    logic              pop;
    logic              spurious;
    logic [ID_W-1:0]   tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Round-robin search: first full slot at or after rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(rr_ptr) + k) % N_CH;
            if (!win_found && slot_full[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Load/grant decision, response pop, and per-channel strobes.
    // A response arriving this cycle frees a tag, so a saturated
    // FIFO can still accept a new request on the same edge.
    always_comb begin
        pop      = mem_rsp_vld && (outstanding != '0);
        spurious = mem_rsp_vld && (outstanding == '0);
        load     = (!mem_req_vld || mem_req_rdy) && win_found &&
                   ((outstanding < MAX_CNT) || mem_rsp_vld);
        for (int i = 0; i < N_CH; i++) begin
            grant[i]      = load && (win_id == ID_W'(i));
            rsp_onehot[i] = pop && (tag_mem[rd_ptr] == ID_W'(i));
        end
    end

    // Per-channel request slots with sticky drop flags.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst) begin
                slot_full[i] <= 1'b0;
                slot_addr[i] <= '0;
                overflow[i]  <= 1'b0;
            end else begin
                if (ch_addr_vld[i] && (!slot_full[i] || grant[i])) begin
                    slot_full[i] <= 1'b1;
                    slot_addr[i] <= ch_addr[i*ADDR_W +: ADDR_W];
                end else if (grant[i]) begin
                    slot_full[i] <= 1'b0;
                end
                if (ch_addr_vld[i] && slot_full[i] && !grant[i]) begin
                    overflow[i] <= 1'b1;
                end
            end
        end
    end

    // Request output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_vld  <= 1'b0;
            mem_req_addr <= '0;
            rr_ptr       <= '0;
        end else if (load) begin
            mem_req_vld  <= 1'b1;
            mem_req_addr <= slot_addr[win_id];
            rr_ptr       <= (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
        end else if (mem_req_rdy) begin
            mem_req_vld  <= 1'b0;
        end
    end

    // Tag FIFO pointers and outstanding count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (load) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            case ({load, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Tag storage. Contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (load) tag_mem[wr_ptr] <= win_id;
    end

    // Registered response routing and sticky spurious-response flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_data_vld  <= '0;
            ch_data      <= '0;
            err_spurious <= 1'b0;
        end else begin
            ch_data_vld <= rsp_onehot;
            if (pop)      ch_data      <= mem_rsp_data;
            if (spurious) err_spurious <= 1'b1;
        end
    end

    assign idle = !(|slot_full) && !mem_req_vld && (outstanding == '0);

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// tb_sha_mem_arbiter: directed scenarios plus randomized traffic against a
// queue-based model of the arbiter and a simple in-order memory responder.
module tb_sha_mem_arbiter;

    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ch_addr_vld;
    logic [N*AW-1:0] ch_addr;
    logic [N-1:0]    ch_data_vld;
    logic [DW-1:0]   ch_data;
    logic            mem_req_vld;
    logic            mem_req_rdy;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_rsp_vld;
    logic [DW-1:0]   mem_rsp_data;
    logic [N-1:0]    overflow;
    logic            err_spurious;
    logic [2:0]      outstanding;
    logic            idle;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // memory responder knobs
    int rdy_pct    = 100;
    int rsp_pct    = 100;
    bit mem_hold   = 0;
    int release_n  = 0;
    bit inject_spur = 0;
    logic [AW-1:0] mem_q [$];

    // logs and scoreboard
    logic [AW-1:0] hs_log [$];
    logic [N-1:0]  rsp_vld_log [$];
    logic [DW-1:0] rsp_dat_log [$];
    logic [DW-1:0] exp_q [$];

    // behavioural model state
    bit            m_pend [N];
    logic [AW-1:0] m_paddr [N];
    logic          m_req_vld;
    logic [AW-1:0] m_req_addr;
    int            tagq [$];
    int            m_last;
    logic [N-1:0]  m_ovf;
    logic [N-1:0]  m_dvld;
    logic [DW-1:0] m_data;
    logic          m_err;

    sha_mem_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .ch_addr_vld(ch_addr_vld), .ch_addr(ch_addr),
        .ch_data_vld(ch_data_vld), .ch_data(ch_data),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_data(mem_rsp_data),
        .overflow(overflow), .err_spurious(err_spurious),
        .outstanding(outstanding), .idle(idle)
    );

    // clock / reset block
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: next-cycle outputs derived from the arbiter's rules.
    always @(posedge clk) begin
        int sz;
        int win;
        int c;
        if (rst) begin
            for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_paddr[i] = '0; end
            m_req_vld = 0; m_req_addr = '0; tagq.delete(); m_last = N - 1;
            m_ovf = '0; m_dvld = '0; m_data = '0; m_err = 0;
        end else begin
            sz = tagq.size();
            m_dvld = '0;
            if (mem_rsp_vld) begin
                if (sz > 0) begin
                    m_dvld[tagq.pop_front()] = 1'b1;
                    m_data = mem_rsp_data;
                end else begin
                    m_err = 1'b1;
                end
            end
            win = -1;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (win < 0 && m_pend[c]) win = c;
            end
            if ((!m_req_vld || mem_req_rdy) && win >= 0 && (sz < MAXO || mem_rsp_vld)) begin
                m_req_vld = 1'b1;
                m_req_addr = m_paddr[win];
                tagq.push_back(win);
                m_last = win;
                m_pend[win] = 0;
            end else if (mem_req_rdy) begin
                m_req_vld = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (ch_addr_vld[i]) begin
                    if (!m_pend[i]) begin
                        m_pend[i] = 1;
                        m_paddr[i] = ch_addr[i*AW +: AW];
                    end else begin
                        m_ovf[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Compare process: every cycle after the active edge.
    initial begin
        bit any_pend;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                any_pend = 0;
                for (int i = 0; i < N; i++) if (m_pend[i]) any_pend = 1;
                chk("mem_req_vld", mem_req_vld, m_req_vld);
                if (m_req_vld) chk("mem_req_addr", mem_req_addr, m_req_addr);
                chk("ch_data_vld", ch_data_vld, m_dvld);
                if (m_dvld != '0) chk("ch_data", ch_data, m_data);
                chk("overflow", overflow, m_ovf);
                chk("err_spurious", err_spurious, m_err);
                chk("outstanding", outstanding, tagq.size());
                chk("idle", idle, !any_pend && !m_req_vld && tagq.size() == 0);
            end
        end
    end

    // Monitor and scoreboard: handshakes, responses, end-to-end data.
    always @(posedge clk) begin
        if (ch_data_vld != '0) begin
            rsp_vld_log.push_back(ch_data_vld);
            rsp_dat_log.push_back(ch_data);
            if (exp_q.size() == 0) chk("sb_unexpected_rsp", ch_data_vld, 0);
            else chk("sb_data", ch_data, exp_q.pop_front());
        end
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
        end else if (mem_req_vld && mem_req_rdy) begin
            mem_q.push_back(mem_req_addr);
            hs_log.push_back(mem_req_addr);
            exp_q.push_back(mem_word(mem_req_addr));
        end
    end

    // Memory responder: random ready, in-order responses.
    initial begin
        mem_req_rdy = 0; mem_rsp_vld = 0; mem_rsp_data = '0;
        forever begin
            @(negedge clk);
            mem_req_rdy = ($urandom_range(0, 99) < rdy_pct);
            if (inject_spur) begin
                mem_rsp_vld = 1; mem_rsp_data = 32'hDEAD_BEEF; inject_spur = 0;
            end else if (mem_q.size() > 0 && (!mem_hold || release_n > 0) &&
                         $urandom_range(0, 99) < rsp_pct) begin
                if (mem_hold) release_n--;
                mem_rsp_vld = 1; mem_rsp_data = mem_word(mem_q.pop_front());
            end else begin
                mem_rsp_vld = 0;
            end
        end
    end

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        hs_log.delete(); rsp_vld_log.delete(); rsp_dat_log.delete();
    endtask

    task automatic do_reset();
        ch_addr_vld = '0; ch_addr = '0;
        rst = 1; cyc(2); rst = 0;
        clear_logs();
    endtask

    task automatic req(input int ch, input logic [AW-1:0] a);
        ch_addr_vld[ch] = 1'b1;
        ch_addr[ch*AW +: AW] = a;
    endtask

    task automatic wait_dvld(input string name, input int max);
        bit seen;
        seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            cyc(1);
            if (ch_data_vld != '0) seen = 1;
        end
        if (!seen) chk(name, 0, 1);
    endtask

    initial begin
        ch_addr_vld = '0; ch_addr = '0; rst = 1;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; ch_addr_vld = '0; ch_addr = '0;
        cyc(3);
        chk("rst_idle", idle, 1);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_req_vld", mem_req_vld, 0);
        chk("rst_dvld", ch_data_vld, 0);
        rst = 0;
        chk_en = 1;

        // 1: single request, latency and routing
        do_reset();
        rdy_pct = 100; rsp_pct = 100;
        req(0, 32'h10); cyc(1);
        ch_addr_vld = '0;
        chk("t1_vld_t1", mem_req_vld, 0);
        cyc(1);
        chk("t1_vld_t2", mem_req_vld, 1);
        chk("t1_addr", mem_req_addr, 32'h10);
        wait_dvld("t1_rsp_timeout", 10);
        chk("t1_dvld", ch_data_vld, 4'b0001);
        chk("t1_data", ch_data, 32'h1312_1110);
        cyc(1);
        chk("t1_idle", idle, 1);

        // 2: all channels at once, issued in channel order
        do_reset();
        rsp_pct = 60;
        for (int i = 0; i < N; i++) req(i, 32'(i * 'h40));
        cyc(1);
        ch_addr_vld = '0;
        cyc(25);
        chk("t2_hs_n", hs_log.size(), 4);
        chk("t2_rsp_n", rsp_vld_log.size(), 4);
        for (int i = 0; i < N && i < hs_log.size(); i++)
            chk("t2_hs_addr", hs_log[i], 32'(i * 'h40));
        for (int i = 0; i < N && i < rsp_vld_log.size(); i++) begin
            chk("t2_rsp_dvld", rsp_vld_log[i], 4'b0001 << i);
            chk("t2_rsp_data", rsp_dat_log[i], mem_word(32'(i * 'h40)));
        end

        // 3: back-pressure holds the request stable
        do_reset();
        rdy_pct = 0; rsp_pct = 100;
        req(0, 32'h300); cyc(1);
        ch_addr_vld = '0;
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_vld", mem_req_vld, 1);
            chk("t3_hold_addr", mem_req_addr, 32'h300);
            cyc(1);
        end
        chk("t3_no_hs", hs_log.size(), 0);
        rdy_pct = 100;
        cyc(6);
        chk("t3_one_hs", hs_log.size(), 1);

        // 4: outstanding saturation and same-cycle refill
        do_reset();
        rdy_pct = 100; mem_hold = 1; release_n = 0;
        for (int k = 0; k < 5; k++) begin
            req(0, 32'(32'h400 + 4 * k)); cyc(1);
            ch_addr_vld = '0; cyc(1);
        end
        cyc(3);
        chk("t4_sat", outstanding, 4);
        chk("t4_hs_n", hs_log.size(), 4);
        chk("t4_waiting", mem_req_vld, 0);
        release_n = 1;
        wait_dvld("t4_rsp_timeout", 10);
        chk("t4_dvld", ch_data_vld, 4'b0001);
        chk("t4_data", ch_data, mem_word(32'h400));
        chk("t4_still_sat", outstanding, 4);
        chk("t4_fifth_vld", mem_req_vld, 1);
        chk("t4_fifth_addr", mem_req_addr, 32'h410);
        mem_hold = 0;
        cyc(15);
        chk("t4_drained", outstanding, 0);

        // 5: overflow while the output register is blocked
        do_reset();
        rdy_pct = 0;
        req(0, 32'h500); cyc(1);
        ch_addr_vld = '0; cyc(2);
        req(1, 32'h100); cyc(1);
        req(1, 32'h104); cyc(1);
        ch_addr_vld = '0; cyc(1);
        chk("t5_overflow", overflow, 4'b0010);
        rdy_pct = 100;
        cyc(10);
        chk("t5_hs_n", hs_log.size(), 2);
        if (hs_log.size() >= 2) begin
            chk("t5_hs0", hs_log[0], 32'h500);
            chk("t5_hs1", hs_log[1], 32'h100);
        end

        // 6: two busy channels alternate; reset mid-stream; late response
        do_reset();
        rdy_pct = 100; rsp_pct = 100;
        for (int n = 0; n < 12; n++) begin
            req(0, 32'(32'h600 + 4 * n));
            req(2, 32'(32'h2600 + 4 * n));
            cyc(1);
        end
        chk("t6_hs_n", hs_log.size() >= 6, 1);
        for (int j = 0; j < 6 && j < hs_log.size(); j++)
            chk("t6_alternate", hs_log[j][13], j % 2);
        rst = 1; cyc(1); rst = 0;
        ch_addr_vld = '0;
        cyc(2);
        inject_spur = 1;
        cyc(3);
        chk("t6_err_spurious", err_spurious, 1);
        chk("t6_no_dvld", ch_data_vld, 0);

        // randomized traffic
        do_reset();
        for (int t = 0; t < 500; t++) begin
            if (t % 50 == 0) begin
                rdy_pct = $urandom_range(0, 100);
                rsp_pct = $urandom_range(20, 100);
            end
            for (int i = 0; i < N; i++) begin
                ch_addr_vld[i] = ($urandom_range(0, 99) < 30);
                ch_addr[i*AW +: AW] = $urandom;
            end
            rst = (t == 250);
            cyc(1);
        end
        rst = 0;
        ch_addr_vld = '0;
        rdy_pct = 100; rsp_pct = 100;
        cyc(30);
        chk("rand_final_idle", idle, 1);
        chk("rand_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
